// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu opcodes, widths and multiplier FSM state encoding
package alu_pkg;

    localparam int DATA_W = 64;
    localparam int OP_W   = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SHL = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EVAL = 3'd1,
        ST_ADD  = 3'd2,
        ST_SHL  = 3'd3,
        ST_SHR  = 3'd4,
        ST_DONE = 3'd5
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational alu: add/sub/and/or, single-bit shifts, compare flags
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [2:0]        ctrl,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] out,
    output logic              greater,
    output logic              lesser,
    output logic              equal
);

    always_comb begin
        out = '0;
        case (ctrl)
            ALU_ADD: out = in_a + in_b;
            ALU_SUB: out = in_a - in_b;
            ALU_AND: out = in_a & in_b;
            ALU_OR:  out = in_a | in_b;
            ALU_SHL: out = in_a << 1;
            ALU_SHR: out = in_a >> 1;
            default: out = '0;
        endcase
    end

    assign greater = (in_a > in_b);
    assign lesser  = (in_a < in_b);
    assign equal   = (in_a == in_b);

endmodule

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 32x32 multiplier sequencing the shared alu
// When idle the host port drives the alu directly; otherwise the FSM owns it.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product,
    input  logic [2:0]        host_ctrl,
    input  logic [DATA_W-1:0] host_a,
    input  logic [DATA_W-1:0] host_b,
    output logic [DATA_W-1:0] host_out,
    output logic              host_stall
);

    mul_state_t        state, state_next;
    logic [DATA_W-1:0] acc, mcand;
    logic [OP_W-1:0]   mplier;

    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic              cmp_gt_unused, cmp_lt_unused, cmp_eq_unused;

    alu #(.DATA_W(DATA_W)) u_alu (
        .ctrl    (alu_ctrl),
        .in_a    (alu_a),
        .in_b    (alu_b),
        .out     (alu_out),
        .greater (cmp_gt_unused),
        .lesser  (cmp_lt_unused),
        .equal   (cmp_eq_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Alu input mux and next state; EVAL leaves the alu on a quiet add of zeros.
    always_comb begin
        state_next = state;
        alu_ctrl   = ALU_ADD;
        alu_a      = '0;
        alu_b      = '0;
        case (state)
            ST_IDLE: begin
                alu_ctrl = host_ctrl;
                alu_a    = host_a;
                alu_b    = host_b;
                if (start) state_next = ST_EVAL;
            end
            ST_EVAL: begin
                if (mplier == '0)   state_next = ST_DONE;
                else if (mplier[0]) state_next = ST_ADD;
                else                state_next = ST_SHL;
            end
            ST_ADD: begin
                alu_a      = acc;
                alu_b      = mcand;
                state_next = ST_SHL;
            end
            ST_SHL: begin
                alu_ctrl   = ALU_SHL;
                alu_a      = mcand;
                state_next = ST_SHR;
            end
            ST_SHR: begin
                alu_ctrl   = ALU_SHR;
                alu_a      = {{(DATA_W-OP_W){1'b0}}, mplier};
                state_next = ST_EVAL;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    acc    <= '0;
                    mcand  <= {{(DATA_W-OP_W){1'b0}}, op_a};
                    mplier <= op_b;
                end
                ST_ADD:  acc     <= alu_out;
                ST_SHL:  mcand   <= alu_out;
                ST_SHR:  mplier  <= alu_out[OP_W-1:0];
                ST_DONE: product <= acc;
                default: ;
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign host_stall = busy;
    assign host_out   = alu_out;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - scoreboard bench for alu_mul_seq against an arithmetic reference
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [63:0] product;
    logic [2:0]  host_ctrl;
    logic [63:0] host_a, host_b, host_out;
    logic        host_stall;

    alu_mul_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .host_ctrl  (host_ctrl),
        .host_a     (host_a),
        .host_b     (host_b),
        .host_out   (host_out),
        .host_stall (host_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    // Cycles from accepted start to done: 2, plus 4 per one and 3 per zero up to the top set bit.
    function automatic int model_lat(input logic [31:0] b);
        int n   = 2;
        int top = -1;
        for (int i = 0; i < 32; i++) if (b[i]) top = i;
        for (int i = 0; i <= top; i++) n += b[i] ? 4 : 3;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    e = sb.pop_front();
                    check("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
                    @(negedge clk);
                    check("product", product, e.prod);
                    check("busy_after_done", {63'b0, busy}, 64'd0);
                end
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int busy_start_at, input bit start_in_done);
        int n = 0;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", {63'b0, busy}, 64'd1);
        sb.push_back('{prod: {32'b0, a} * {32'b0, b}, lat: model_lat(b), t0: cyc});
        while (!done && n < 200) begin
            check("host_stall_busy", {63'b0, host_stall}, 64'd1);
            host_ctrl = 3'($urandom_range(0, 7));
            host_a    = {$urandom, $urandom};
            host_b    = {$urandom, $urandom};
            if (n == busy_start_at) begin
                start = 1'b1;
                op_a  = $urandom;
                op_b  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected within 200 cycles");
        end
        if (start_in_done) begin
            start = 1'b1;
            op_a  = $urandom;
            op_b  = $urandom;
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done_ignored", {63'b0, busy}, 64'd0);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op_a      = '0;
        op_b      = '0;
        host_ctrl = '0;
        host_a    = '0;
        host_b    = '0;
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_stall", {63'b0, host_stall}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Abort mid-operation.
        op_a  = 32'h0000_ABCD;
        op_b  = 32'h0000_00FF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back('{prod: 64'h0, lat: 0, t0: cyc});
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'd3, 32'd5, -1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(32'h0000_1234, 32'd0, -1, 1'b0);
        run_op(32'd0, 32'd7, -1, 1'b0);

        host_ctrl = 3'b001;
        host_a    = 64'd10;
        host_b    = 64'd3;
        #1;
        check("host_sub", host_out, 64'd7);
        check("host_stall_idle", {63'b0, host_stall}, 64'd0);
        host_ctrl = 3'b011;
        host_a    = 64'hF0F0_0000_0000_0001;
        host_b    = 64'h0F00_0000_0000_0010;
        #1;
        check("host_or", host_out, 64'hFFF0_0000_0000_0011);
        @(posedge clk); #1;

        run_op(32'h0001_1111, 32'h0000_2345, 5, 1'b0);
        run_op(32'h8765_4321, 32'h0000_0013, 3, 1'b1);
        run_op(32'hDEAD_BEEF, 32'h0000_0009, -1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom >> $urandom_range(0, 31),
                   int'($urandom_range(0, 30)) - 10, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
